seg_serial_decoder: RTL

Receiver for the serial 7-segment display stream: deserializes the shift-clock/data/latch bitstream that drives the board's segment shift registers, and decodes each 8-bit segment byte back to a hex nibble, point flag and blank/invalid status. Sits beside the display driver as a readback monitor for self-check and for the verification bench. It is the inverse of the hex-to-segment encoder path.

---
 rtl/seg_serial_decoder_pkg.sv | 38 +++
 rtl/seg_serial_decoder_if.sv | 29 ++
 rtl/seg_serial_decoder_pattern_decode.sv | 37 +++
 rtl/seg_serial_decoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seg_serial_decoder_pkg.sv
// seg7_pkg: glyph table, frame sizing and counter width for the serial
// 7-segment readback decoder.
package seg7_pkg;

  localparam int DIGITS_DEF = 8;
  localparam int FRAME_BITS = 8 * DIGITS_DEF;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  // Active-high {a,b,c,d,e,f,g}
  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G6 = 7'b1011111;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] G9 = 7'b1111011;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GB = 7'b0011111;
  localparam logic [6:0] GC = 7'b1001110;
  localparam logic [6:0] GD = 7'b0111101;
  localparam logic [6:0] GE = 7'b1001111;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] BLANK = 7'b0000000;

  // GLYPH[n] is the pattern for nibble n
  localparam logic [15:0][6:0] GLYPH = {
    GF, GE, GD, GC, GB, GA, G9, G8,
    G7, G6, G5, G4, G3, G2, G1, G0
  };

  function automatic int cnt_width(int digits);
    return $clog2(8 * digits + 2);
  endfunction

endpackage

// File: rtl/seg_serial_decoder_if.sv
// Serial segment stream in (master drives) and decoded frame out.
// Ports: seg_clk/seg_sout/seg_pen stream; hex/point/blank/invalid, pulses.
interface seg_serial_decoder_if #(
  parameter int DIGITS = 8
);

  logic                  seg_clk;
  logic                  seg_sout;
  logic                  seg_pen;
  logic [4*DIGITS-1:0]   hex;
  logic [DIGITS-1:0]     point;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS-1:0]     invalid;
  logic                  frame_valid;
  logic                  frame_err;

  modport master (
    output seg_clk, seg_sout, seg_pen,
    input  hex, point, blank, invalid,
    input  frame_valid, frame_err
  );

  modport slave (
    input  seg_clk, seg_sout, seg_pen,
    output hex, point, blank, invalid,
    output frame_valid, frame_err
  );

endinterface

// File: rtl/seg_serial_decoder_pattern_decode.sv
// seg7_pattern_decode: one active-low {a..g,p} byte to nibble/flags.
// Ports: seg_i byte in; hex_o, point_o, blank_o, invalid_o out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg_i,
  output logic [3:0] hex_o,
  output logic       point_o,
  output logic       blank_o,
  output logic       invalid_o
);

  logic [6:0] segs;
  logic       hit;

  assign segs    = ~seg_i[7:1];
  assign point_o = ~seg_i[0];

  always_comb begin
    hex_o     = 4'h0;
    hit       = 1'b0;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (segs == GLYPH[i]) begin
        hex_o = 4'(i);
        hit   = 1'b1;
      end
    end
    if (segs == BLANK) begin
      blank_o = 1'b1;
    end else if (!hit) begin
      invalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/seg_serial_decoder.sv
// seg_serial_decoder: readback of the serial segment stream into digits.
// Ports: clk, rst_n (async low), bus (slave: stream in, decoded out).
module seg_serial_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_serial_decoder_if.slave   bus
);

  localparam int FB = 8 * DIGITS;
  localparam int CW = cnt_width(DIGITS);
  localparam logic [CW-1:0] SAT  = CW'(FB + 1);
  localparam logic [CW-1:0] FULL = CW'(FB);

  logic [2:0]          clk_s_q;
  logic [1:0]          dat_s_q;
  logic [2:0]          pen_s_q;
  logic                clk_rise;
  logic                pen_rise;

  logic [FB-1:0]       sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_sh, cnt_d;

  logic [4*DIGITS-1:0] hex_q, hex_d, dec_hex;
  logic [DIGITS-1:0]   pt_q, pt_d, dec_pt;
  logic [DIGITS-1:0]   bl_q, bl_d, dec_bl;
  logic [DIGITS-1:0]   inv_q, inv_d, dec_inv;
  logic                fv_q, fv_d;
  logic                fe_q, fe_d;

  assign clk_rise = clk_s_q[1] & ~clk_s_q[2];
  assign pen_rise = pen_s_q[1] & ~pen_s_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s_q <= '0;
      dat_s_q <= '0;
      pen_s_q <= '0;
    end else begin
      clk_s_q <= {clk_s_q[1:0], bus.seg_clk};
      dat_s_q <= {dat_s_q[0], bus.seg_sout};
      pen_s_q <= {pen_s_q[1:0], bus.seg_pen};
    end
  end

  // Shift first; the latch below sees the post-shift data and count.
  always_comb begin
    sh_d   = sh_q;
    cnt_sh = cnt_q;
    if (clk_rise) begin
      sh_d = {sh_q[FB-2:0], dat_s_q[1]};
      if (cnt_q != SAT) begin
        cnt_sh = cnt_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_pattern_decode u_dec (
      .seg_i     (sh_d[8*k +: 8]),
      .hex_o     (dec_hex[4*k +: 4]),
      .point_o   (dec_pt[k]),
      .blank_o   (dec_bl[k]),
      .invalid_o (dec_inv[k])
    );
  end

  always_comb begin
    cnt_d = cnt_sh;
    hex_d = hex_q;
    pt_d  = pt_q;
    bl_d  = bl_q;
    inv_d = inv_q;
    fv_d  = 1'b0;
    fe_d  = 1'b0;
    if (pen_rise) begin
      cnt_d = '0;
      if (cnt_sh == FULL) begin
        hex_d = dec_hex;
        pt_d  = dec_pt;
        bl_d  = dec_bl;
        inv_d = dec_inv;
        fv_d  = 1'b1;
      end else begin
        fe_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      hex_q <= '0;
      pt_q  <= '0;
      bl_q  <= '1;
      inv_q <= '0;
      fv_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      hex_q <= hex_d;
      pt_q  <= pt_d;
      bl_q  <= bl_d;
      inv_q <= inv_d;
      fv_q  <= fv_d;
      fe_q  <= fe_d;
    end
  end

  assign bus.hex         = hex_q;
  assign bus.point       = pt_q;
  assign bus.blank       = bl_q;
  assign bus.invalid     = inv_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;

endmodule
